wr_ctrl_flags: RTL and testbench
================================

Name: wr_ctrl_flags

Overview:
- Write-domain control block for the dual-clock FIFO. A parametrised successor of the basic write-pointer/full logic.
- Generates the write address, the write enable and the Gray write pointer for the read domain.
- Owns an internal N-stage synchroniser for the incoming read Gray pointer.
- Adds an exact used-word count covering 0..DEPTH, a programmable almost-full flag, and a sticky overflow flag with clear.

Parameters:
- AWIDTH, 4, address width; DEPTH = 2**AWIDTH words.
- SYNC_STAGES, 2, flip-flop stages on rd_pntr_gray_i; legal range 2..4.
- AFULL_LEVEL, 2**AWIDTH-2, almost-full asserts when used words >= this value; legal range 1..DEPTH.

Ports:
- wr_clk_i  in  1  write-domain clock.
- aclr_i  in  1  asynchronous, active-low reset.
- wr_req_i  in  1  write request.
- ovf_clr_i  in  1  clears wr_ovf_o.
- rd_pntr_gray_i  in  AWIDTH+1  read pointer, Gray-coded, from the read clock domain (asynchronous to wr_clk_i).
- wr_pntr_o  out  AWIDTH  memory write address (binary).
- wr_en_o  out  1  write accepted this cycle (combinational).
- wr_pntr_gray_o  out  AWIDTH+1  registered Gray write pointer, sent to the read domain.
- wr_full_o  out  1  FIFO full.
- wr_afull_o  out  1  almost full.
- wr_usedw_o  out  AWIDTH+1  words in the FIFO as seen from the write side.
- wr_ovf_o  out  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset (aclr_i low, asserts asynchronously):
  - All registers clear, including every synchroniser stage.
  - wr_pntr_o=0, wr_pntr_gray_o=0, wr_full_o=0, wr_afull_o=0 (or 1 only if AFULL_LEVEL would be reached at 0, which is illegal), wr_usedw_o=0, wr_ovf_o=0.
  - Reset asserted mid-operation discards all state; the first edge after release behaves as the first cycle after reset.
- Synchroniser:
  - rd_pntr_gray_i is shifted through SYNC_STAGES registers.
  - The last stage is converted Gray->binary (AWIDTH+1 bits, full width) giving rd_bin_s.
- Write accept:
  - wr_en_o = wr_req_i & ~wr_full_o.
  - wr_bin (AWIDTH+1 bits) increments by wr_en_o every cycle.
  - wr_bin wraps modulo 2**(AWIDTH+1); the wrap bit is retained.
  - wr_pntr_o = wr_bin[AWIDTH-1:0].
  - wr_pntr_gray_o registers bin2gray(wr_bin_next), so it always equals the Gray code of wr_pntr.
- Used count:
  - usedw_next = wr_bin_next - rd_bin_s, modulo 2**(AWIDTH+1); range 0..DEPTH.
  - wr_usedw_o is registered and reflects writes with zero extra latency: it updates in the same edge as the pointer.
- Flags (all registered from next-state values):
  - wr_full_o = (usedw_next == DEPTH).
  - wr_afull_o = (usedw_next >= AFULL_LEVEL).
- Latency:
  - A read-pointer change on rd_pntr_gray_i reaches wr_usedw_o / wr_full_o / wr_afull_o after SYNC_STAGES+1 write clocks.
  - Flags are therefore pessimistic: full may stay high after a read, but the FIFO can never overflow.
- Overflow:
  - wr_ovf_o sets on the edge where wr_req_i & wr_full_o.
  - Clears on ovf_clr_i.
  - Set has priority over a simultaneous clear.
  - The rejected write does not move any pointer.
- Boundaries:
  - Write at usedw=DEPTH-1 -> full next cycle.
  - Simultaneous write and read-pointer advance: count reflects both once the read is synchronised.
  - Wrap of wr_bin from 2**(AWIDTH+1)-1 to 0 must not disturb usedw or flags.

Decomposition:
- Package fifo_pkg: functions bin2gray and gray2bin, parametrised by width through a width-generic implementation of AWIDTH+1 bits, plus localparam-style DEPTH helpers.
- One sub-module: gray_ptr_sync (params WIDTH, STAGES; ports clk, async active-low reset, d, q), reused later by the read-side controller.

Test Plan:
- Reset: hold aclr_i low with random inputs -> all outputs 0. Pulse reset mid-fill (usedw=7) -> outputs 0 immediately, asynchronously.
- Fill (AWIDTH=4, rd_pntr_gray_i=0, wr_req_i=1 for 20 cycles):
  - wr_pntr_o counts 0..15.
  - wr_afull_o rises with wr_usedw_o=14.
  - wr_full_o rises with wr_usedw_o=16; wr_en_o then 0.
  - wr_ovf_o=1 on the next cycle.
- Drain visibility: while full, drive rd_pntr_gray_i=5'b00001 -> wr_full_o falls and wr_usedw_o=15 exactly SYNC_STAGES+1 clocks later; repeat with SYNC_STAGES=3.
- Wrap-around: stream writes with rd_pntr_gray_i tracking writes-8 for 70 writes.
  - wr_bin passes 31->0.
  - wr_usedw_o stays 8; wr_full_o and wr_afull_o stay 0.
  - wr_pntr_gray_o always equals bin2gray of the binary pointer with only 1 bit changing per step.
- Overflow clear: with full, assert wr_req_i and ovf_clr_i together -> wr_ovf_o=1. Then ovf_clr_i alone with wr_req_i=0 -> wr_ovf_o=0 next cycle.
- Threshold param: AFULL_LEVEL=DEPTH -> wr_afull_o and wr_full_o assert on the same edge; AFULL_LEVEL=1 -> wr_afull_o rises after the first write.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkg
//  Purpose  : Shared types and helpers for the dual-clock FIFO controllers.
//             Gray/binary conversions are written once on a wide word.
//             Callers zero-extend their pointer into the word and keep the
//             low AWIDTH+1 bits. Zero-extension leaves both conversions
//             exact for any narrower width.
//  Revision : 1.0  initial parametrised release
// ============================================================================
package fifo_pkg;

    // Widest pointer the generic conversion helpers accept.
    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    // Registered status flags of the write-side controller.
    typedef struct packed {
        logic full;
        logic afull;
        logic ovf;
    } wr_flags_t;

    // Number of words held by a FIFO with the given address width.
    function automatic int depth_of(input int awidth);
        return 1 << awidth;
    endfunction

    // Pointer width: one extra bit above the address distinguishes full from
    // empty when the addresses are equal.
    function automatic int ptr_width_of(input int awidth);
        return awidth + 1;
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of its own Gray bit and every Gray bit above it.
    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = g;
        for (int i = 1; i < PTR_MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wr_ctrl_flags_if.sv
`default_nettype none
// ============================================================================
//  Module   : wr_ctrl_flags_if
//  Purpose  : Bundle of the write-side request and status signals of the
//             dual-clock FIFO.
//  Ports    : wr_req_i, ovf_clr_i, rd_pntr_gray_i   -> controller
//             wr_pntr_o, wr_en_o, wr_pntr_gray_o,
//             wr_full_o, wr_afull_o, wr_usedw_o,
//             wr_ovf_o                              <- controller
//             master : the writer / surrounding FIFO logic
//             slave  : the write-side controller
//  Revision : 1.0  initial parametrised release
// ============================================================================
interface wr_ctrl_flags_if #(
    parameter int AWIDTH = 4
);
    logic              wr_req_i;
    logic              ovf_clr_i;
    logic [AWIDTH:0]   rd_pntr_gray_i;
    logic [AWIDTH-1:0] wr_pntr_o;
    logic              wr_en_o;
    logic [AWIDTH:0]   wr_pntr_gray_o;
    logic              wr_full_o;
    logic              wr_afull_o;
    logic [AWIDTH:0]   wr_usedw_o;
    logic              wr_ovf_o;

    modport master (
        output wr_req_i,
        output ovf_clr_i,
        output rd_pntr_gray_i,
        input  wr_pntr_o,
        input  wr_en_o,
        input  wr_pntr_gray_o,
        input  wr_full_o,
        input  wr_afull_o,
        input  wr_usedw_o,
        input  wr_ovf_o
    );

    modport slave (
        input  wr_req_i,
        input  ovf_clr_i,
        input  rd_pntr_gray_i,
        output wr_pntr_o,
        output wr_en_o,
        output wr_pntr_gray_o,
        output wr_full_o,
        output wr_afull_o,
        output wr_usedw_o,
        output wr_ovf_o
    );

endinterface
`default_nettype wire

// File: rtl/gray_ptr_sync.sv
`default_nettype none
// ============================================================================
//  Module   : gray_ptr_sync
//  Purpose  : Multi-stage flip-flop synchroniser for a Gray-coded pointer
//             crossing into the clk domain. Gray coding guarantees at most
//             one bit is in flight. A metastable capture resolves to either
//             the old pointer or the new pointer.
//  Ports    : clk   in  destination clock
//             rst_n in  asynchronous active-low reset, clears every stage
//             d     in  WIDTH  pointer from the source domain
//             q     out WIDTH  synchronised pointer (last stage)
//  Revision : 1.0  initial release
// ============================================================================
module gray_ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/wr_ctrl_flags.sv
`default_nettype none
// ============================================================================
//  Module   : wr_ctrl_flags
//  Purpose  : Write-domain controller of the dual-clock FIFO.
//             Produces:
//               - the write address and write enable,
//               - the Gray write pointer for the read domain,
//               - an exact used-word count (0..DEPTH),
//               - full, almost-full and sticky overflow flags.
//             The read pointer arrives Gray-coded. It is synchronised over
//             SYNC_STAGES flops inside this block.
//  Ports    : wr_clk_i  in   write-domain clock
//             aclr_i    in   asynchronous active-low reset
//             bus       slave modport of wr_ctrl_flags_if:
//                         wr_req_i, ovf_clr_i, rd_pntr_gray_i (in)
//                         wr_pntr_o, wr_en_o, wr_pntr_gray_o,
//                         wr_full_o, wr_afull_o, wr_usedw_o, wr_ovf_o (out)
//  Params   : AWIDTH       address width, DEPTH = 2**AWIDTH
//             SYNC_STAGES  read-pointer synchroniser depth, 2..4
//             AFULL_LEVEL  almost-full threshold in words, 1..DEPTH
//  Revision : 1.0  initial parametrised release
// ============================================================================
module wr_ctrl_flags
    import fifo_pkg::*;
#(
    parameter int AWIDTH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_LEVEL = (2**AWIDTH) - 2
) (
    input  logic            wr_clk_i,
    input  logic            aclr_i,
    wr_ctrl_flags_if.slave  bus
);

    localparam int              PTR_W   = ptr_width_of(AWIDTH);
    localparam int              DEPTH   = depth_of(AWIDTH);
    localparam logic [PTR_W-1:0] C_DEPTH = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] C_AFULL = PTR_W'(AFULL_LEVEL);
    localparam int              EXT_W   = PTR_MAX_W - PTR_W;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] r_wr_bin;
    logic [PTR_W-1:0] r_wr_gray;
    logic [PTR_W-1:0] r_usedw;
    wr_flags_t        r_flags;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    logic             w_wr_en;
    logic [PTR_W-1:0] w_wr_bin_next;
    logic [PTR_W-1:0] w_wr_gray_next;
    logic [PTR_W-1:0] w_usedw_next;
    logic [PTR_W-1:0] w_rd_gray_s;
    logic [PTR_W-1:0] w_rd_bin_s;
    ptr_word_t        w_rd_bin_ext;
    ptr_word_t        w_wr_gray_ext;
    logic             w_unused_ext;

    // ------------------------------------------------------------------
    // Read pointer into the write domain
    // ------------------------------------------------------------------
    gray_ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_rd_sync (
        .clk   (wr_clk_i),
        .rst_n (aclr_i),
        .d     (bus.rd_pntr_gray_i),
        .q     (w_rd_gray_s)
    );

    // The full pointer width is converted. The wrap bit is part of the
    // distance calculation.
    assign w_rd_bin_ext = gray2bin({{EXT_W{1'b0}}, w_rd_gray_s});
    assign w_rd_bin_s   = w_rd_bin_ext[PTR_W-1:0];

    // ------------------------------------------------------------------
    // Write accept and pointer advance
    // ------------------------------------------------------------------
    assign w_wr_en       = bus.wr_req_i & ~r_flags.full;
    assign w_wr_bin_next = r_wr_bin + {{AWIDTH{1'b0}}, w_wr_en};

    assign w_wr_gray_ext  = bin2gray({{EXT_W{1'b0}}, w_wr_bin_next});
    assign w_wr_gray_next = w_wr_gray_ext[PTR_W-1:0];

    // Both pointers carry the wrap bit. The modulo-2**PTR_W difference is
    // the exact fill level, including across the 2**PTR_W-1 -> 0 wrap.
    assign w_usedw_next = w_wr_bin_next - w_rd_bin_s;

    // Upper bits of the wide conversion words are zero by construction.
    assign w_unused_ext = ^{w_rd_bin_ext[PTR_MAX_W-1:PTR_W],
                            w_wr_gray_ext[PTR_MAX_W-1:PTR_W]};

    // ------------------------------------------------------------------
    // Registers
    // Flags are computed from next-state values. They therefore change on
    // the same edge as the pointer and the count they describe.
    // ------------------------------------------------------------------
    always_ff @(posedge wr_clk_i or negedge aclr_i) begin
        if (!aclr_i) begin
            r_wr_bin  <= '0;
            r_wr_gray <= '0;
            r_usedw   <= '0;
            r_flags   <= '0;
        end else begin
            r_wr_bin      <= w_wr_bin_next;
            r_wr_gray     <= w_wr_gray_next;
            r_usedw       <= w_usedw_next;
            r_flags.full  <= (w_usedw_next == C_DEPTH);
            r_flags.afull <= (w_usedw_next >= C_AFULL);
            // A rejected write wins over a simultaneous clear, so no
            // overflow event is ever lost.
            if (bus.wr_req_i && r_flags.full) begin
                r_flags.ovf <= 1'b1;
            end else if (bus.ovf_clr_i) begin
                r_flags.ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.wr_pntr_o      = r_wr_bin[AWIDTH-1:0];
    assign bus.wr_en_o        = w_wr_en;
    assign bus.wr_pntr_gray_o = r_wr_gray;
    assign bus.wr_full_o      = r_flags.full;
    assign bus.wr_afull_o     = r_flags.afull;
    assign bus.wr_usedw_o     = r_usedw;
    assign bus.wr_ovf_o       = r_flags.ovf;

endmodule
`default_nettype wire

// File: tb/tb_wr_ctrl_flags.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wr_ctrl_flags
//  Purpose  : Directed self-checking bench for wr_ctrl_flags.
//             Four instances share one stimulus:
//               dut_a  defaults (SYNC_STAGES=2, AFULL_LEVEL=14)
//               dut_b  SYNC_STAGES=3
//               dut_c  AFULL_LEVEL=DEPTH
//               dut_d  AFULL_LEVEL=1
//  Revision : 1.0  initial release
// ============================================================================
module tb_wr_ctrl_flags;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          wr_clk_i = 1'b0;
    logic          aclr_i;
    logic          req;
    logic          clr;
    logic [AW:0]   rdg;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 wr_clk_i = ~wr_clk_i;

    wr_ctrl_flags_if #(.AWIDTH(AW)) if_a ();
    wr_ctrl_flags_if #(.AWIDTH(AW)) if_b ();
    wr_ctrl_flags_if #(.AWIDTH(AW)) if_c ();
    wr_ctrl_flags_if #(.AWIDTH(AW)) if_d ();

    assign if_a.wr_req_i = req;  assign if_a.ovf_clr_i = clr;  assign if_a.rd_pntr_gray_i = rdg;
    assign if_b.wr_req_i = req;  assign if_b.ovf_clr_i = clr;  assign if_b.rd_pntr_gray_i = rdg;
    assign if_c.wr_req_i = req;  assign if_c.ovf_clr_i = clr;  assign if_c.rd_pntr_gray_i = rdg;
    assign if_d.wr_req_i = req;  assign if_d.ovf_clr_i = clr;  assign if_d.rd_pntr_gray_i = rdg;

    wr_ctrl_flags #(.AWIDTH(AW)) dut_a (
        .wr_clk_i (wr_clk_i), .aclr_i (aclr_i), .bus (if_a.slave));
    wr_ctrl_flags #(.AWIDTH(AW), .SYNC_STAGES(3)) dut_b (
        .wr_clk_i (wr_clk_i), .aclr_i (aclr_i), .bus (if_b.slave));
    wr_ctrl_flags #(.AWIDTH(AW), .AFULL_LEVEL(DEPTH)) dut_c (
        .wr_clk_i (wr_clk_i), .aclr_i (aclr_i), .bus (if_c.slave));
    wr_ctrl_flags #(.AWIDTH(AW), .AFULL_LEVEL(1)) dut_d (
        .wr_clk_i (wr_clk_i), .aclr_i (aclr_i), .bus (if_d.slave));

    function automatic logic [AW:0] gray5(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reset all instances, then release one time unit after an edge.
    task automatic do_reset();
        aclr_i = 1'b0;
        req    = 1'b0;
        clr    = 1'b0;
        rdg    = '0;
        repeat (2) @(posedge wr_clk_i);
        #1 aclr_i = 1'b1;
    endtask

    task automatic test_reset();
        logic [18:0] st;
        aclr_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge wr_clk_i);
            #1;
            req = 1'($urandom);
            clr = 1'($urandom);
            rdg = 5'($urandom);
            st  = {if_a.wr_pntr_o, if_a.wr_pntr_gray_o, if_a.wr_full_o,
                   if_a.wr_afull_o, if_a.wr_usedw_o, if_a.wr_ovf_o};
            n_tests++;
            if (st !== '0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d: got state %h expected 0", i, st);
            end
            n_tests++;
            if (if_d.wr_afull_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold_afull_d: got %b expected 0", if_d.wr_afull_o);
            end
        end
        req = 1'b0; clr = 1'b0; rdg = '0;
        #1 aclr_i = 1'b1;
    endtask

    task automatic test_async_reset_midfill();
        logic [18:0] st;
        req = 1'b1; clr = 1'b0; rdg = '0;
        repeat (7) @(posedge wr_clk_i);
        #1;
        n_tests++;
        if (if_a.wr_usedw_o !== 5'd7) begin
            n_fail++;
            $display("FAIL midfill_usedw: got %0d expected 7", if_a.wr_usedw_o);
        end
        // Assert reset between edges: outputs must clear without a clock.
        #2 aclr_i = 1'b0;
        #1;
        st = {if_a.wr_pntr_o, if_a.wr_pntr_gray_o, if_a.wr_full_o,
              if_a.wr_afull_o, if_a.wr_usedw_o, if_a.wr_ovf_o};
        n_tests++;
        if (st !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got state %h expected 0", st);
        end
        @(posedge wr_clk_i);
        #1 aclr_i = 1'b1;
        @(posedge wr_clk_i);
        #1;
        n_tests++;
        if (if_a.wr_usedw_o !== 5'd1 || if_a.wr_pntr_o !== 4'd1) begin
            n_fail++;
            $display("FAIL post_reset_first: got usedw=%0d pntr=%0d expected 1/1",
                     if_a.wr_usedw_o, if_a.wr_pntr_o);
        end
    endtask

    task automatic test_fill();
        int n;
        int np;
        req = 1'b1; clr = 1'b0; rdg = '0;
        #1;
        for (int e = 1; e <= 20; e++) begin
            np = (e - 1 > 16) ? 16 : e - 1;
            n_tests++;
            if (if_a.wr_en_o !== (np < 16)) begin
                n_fail++;
                $display("FAIL fill_wr_en e=%0d: got %b expected %b", e, if_a.wr_en_o, (np < 16));
            end
            @(posedge wr_clk_i);
            #1;
            n = (e > 16) ? 16 : e;
            n_tests++;
            if (if_a.wr_pntr_o !== 4'(n) || if_a.wr_usedw_o !== 5'(n)) begin
                n_fail++;
                $display("FAIL fill_ptr e=%0d: got pntr=%0d usedw=%0d expected %0d/%0d",
                         e, if_a.wr_pntr_o, if_a.wr_usedw_o, n % 16, n);
            end
            n_tests++;
            if (if_a.wr_pntr_gray_o !== gray5(5'(n))) begin
                n_fail++;
                $display("FAIL fill_gray e=%0d: got %b expected %b", e, if_a.wr_pntr_gray_o, gray5(5'(n)));
            end
            n_tests++;
            if (if_a.wr_full_o !== (n == 16) || if_a.wr_afull_o !== (n >= 14)) begin
                n_fail++;
                $display("FAIL fill_flags e=%0d: got full=%b afull=%b expected %b/%b",
                         e, if_a.wr_full_o, if_a.wr_afull_o, (n == 16), (n >= 14));
            end
            n_tests++;
            if (if_a.wr_ovf_o !== (e >= 17)) begin
                n_fail++;
                $display("FAIL fill_ovf e=%0d: got %b expected %b", e, if_a.wr_ovf_o, (e >= 17));
            end
            n_tests++;
            if (if_c.wr_afull_o !== (n == 16) || if_c.wr_full_o !== (n == 16)) begin
                n_fail++;
                $display("FAIL thresh_depth e=%0d: got afull=%b full=%b expected %b/%b",
                         e, if_c.wr_afull_o, if_c.wr_full_o, (n == 16), (n == 16));
            end
            n_tests++;
            if (if_d.wr_afull_o !== 1'b1) begin
                n_fail++;
                $display("FAIL thresh_one e=%0d: got %b expected 1", e, if_d.wr_afull_o);
            end
        end
    endtask

    task automatic test_drain();
        logic ef;
        req = 1'b0;
        rdg = 5'b00001;
        for (int e = 1; e <= 4; e++) begin
            @(posedge wr_clk_i);
            #1;
            ef = (e < 3);
            n_tests++;
            if (if_a.wr_full_o !== ef || if_a.wr_usedw_o !== (ef ? 5'd16 : 5'd15)) begin
                n_fail++;
                $display("FAIL drain_s2 e=%0d: got full=%b usedw=%0d expected %b/%0d",
                         e, if_a.wr_full_o, if_a.wr_usedw_o, ef, ef ? 16 : 15);
            end
            ef = (e < 4);
            n_tests++;
            if (if_b.wr_full_o !== ef || if_b.wr_usedw_o !== (ef ? 5'd16 : 5'd15)) begin
                n_fail++;
                $display("FAIL drain_s3 e=%0d: got full=%b usedw=%0d expected %b/%0d",
                         e, if_b.wr_full_o, if_b.wr_usedw_o, ef, ef ? 16 : 15);
            end
        end
    endtask

    // Starts at usedw=15, pointer 16, read pointer 1, overflow already set.
    task automatic test_overflow_clear();
        logic [3:0] ereq [5] = '{1, 1, 0, 0, 1};
        logic [3:0] eclr [5] = '{0, 1, 1, 0, 0};
        logic       eovf [5] = '{1, 1, 0, 0, 1};
        for (int s = 0; s < 5; s++) begin
            req = ereq[s][0];
            clr = eclr[s][0];
            @(posedge wr_clk_i);
            #1;
            n_tests++;
            if (if_a.wr_ovf_o !== eovf[s]) begin
                n_fail++;
                $display("FAIL ovf_clr s=%0d: got %b expected %b", s, if_a.wr_ovf_o, eovf[s]);
            end
            n_tests++;
            if (if_a.wr_full_o !== 1'b1 || if_a.wr_pntr_o !== 4'd1 || if_a.wr_usedw_o !== 5'd16) begin
                n_fail++;
                $display("FAIL ovf_hold s=%0d: got full=%b pntr=%0d usedw=%0d expected 1/1/16",
                         s, if_a.wr_full_o, if_a.wr_pntr_o, if_a.wr_usedw_o);
            end
        end
        req = 1'b0;
        clr = 1'b0;
    endtask

    // Read pointer follows the writes so the synchronised view keeps
    // exactly 8 words: it is driven 3 writes ahead of (writes - 8) to cover
    // the two-stage synchroniser plus the count register.
    task automatic test_wrap();
        logic [AW:0] prev_g;
        prev_g = '0;
        req = 1'b1; clr = 1'b0; rdg = '0;
        for (int k = 1; k <= 78; k++) begin
            @(posedge wr_clk_i);
            #1;
            n_tests++;
            if (if_a.wr_pntr_gray_o !== gray5(5'(k)) || if_a.wr_pntr_o !== 4'(k)) begin
                n_fail++;
                $display("FAIL wrap_ptr k=%0d: got gray=%b pntr=%0d expected %b/%0d",
                         k, if_a.wr_pntr_gray_o, if_a.wr_pntr_o, gray5(5'(k)), k % 16);
            end
            n_tests++;
            if ($countones(if_a.wr_pntr_gray_o ^ prev_g) != 1) begin
                n_fail++;
                $display("FAIL wrap_gray_step k=%0d: got %b after %b expected one bit change",
                         k, if_a.wr_pntr_gray_o, prev_g);
            end
            prev_g = if_a.wr_pntr_gray_o;
            if (k >= 8) begin
                n_tests++;
                if (if_a.wr_usedw_o !== 5'd8 || if_a.wr_full_o !== 1'b0 || if_a.wr_afull_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wrap_level k=%0d: got usedw=%0d full=%b afull=%b expected 8/0/0",
                             k, if_a.wr_usedw_o, if_a.wr_full_o, if_a.wr_afull_o);
                end
            end
            rdg = (k >= 5) ? gray5(5'(k - 5)) : '0;
        end
        req = 1'b0;
    endtask

    initial begin
        aclr_i = 1'b0;
        req    = 1'b0;
        clr    = 1'b0;
        rdg    = '0;
        test_reset();
        test_async_reset_midfill();
        do_reset();
        test_fill();
        test_drain();
        test_overflow_clear();
        do_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
